// File: rtl/issue_pkg.sv
// Shared definitions for the issue queue: unit opcodes, instruction field
// positions, the decoded issue record, the halt-sequencing state and the decoder.
package issue_pkg;

  localparam int IQ_WORD_SIZE = 32;
  localparam int IQ_REG_SIZE  = 6;

  localparam logic [2:0] UNIT_LW   = 3'b000;
  localparam logic [2:0] UNIT_SW   = 3'b001;
  localparam logic [2:0] UNIT_ADD  = 3'b010;
  localparam logic [2:0] UNIT_MUL  = 3'b011;
  localparam logic [2:0] UNIT_MV   = 3'b100;
  localparam logic [2:0] UNIT_HALT = 3'b101;

  localparam int UNIT_HI    = 31;
  localparam int UNIT_LO    = 29;
  localparam int HASIMM_BIT = 28;
  localparam int REG1_HI    = 27;
  localparam int REG1_LO    = 22;
  localparam int REG2_HI    = 21;
  localparam int REG2_LO    = 16;
  localparam int REG3_HI    = 15;
  localparam int REG3_LO    = 10;
  localparam int IMM_HI     = 15;
  localparam int IMM_LO     = 0;

  typedef struct packed {
    logic [2:0]              unit;
    logic [IQ_REG_SIZE-1:0]  reg1;
    logic [IQ_REG_SIZE-1:0]  reg2;
    logic [IQ_REG_SIZE-1:0]  reg3;
    logic                    hasimm;
    logic [IQ_WORD_SIZE-1:0] imm;
  } issue_fields_t;

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } iq_state_t;

  // Opcodes 110 and 111 are unassigned.
  function automatic logic unit_is_illegal(input logic [2:0] unit);
    return unit[2] & unit[1];
  endfunction

  // reg3 and the immediate share bits [15:*]; only one of them is ever nonzero.
  function automatic issue_fields_t decode_word(input logic [31:0] word);
    issue_fields_t fields;
    fields        = '0;
    fields.unit   = word[UNIT_HI:UNIT_LO];
    fields.hasimm = word[HASIMM_BIT];
    fields.reg1   = word[REG1_HI:REG1_LO];
    fields.reg2   = word[REG2_HI:REG2_LO];
    if (word[HASIMM_BIT])
      fields.imm = {{(IQ_WORD_SIZE-16){word[IMM_HI]}}, word[IMM_HI:IMM_LO]};
    else
      fields.reg3 = word[REG3_HI:REG3_LO];
    return fields;
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side and RS-side handshake bundle of the issue queue.
// master = the queue itself, slave = fetch/RS environment.
interface issue_queue_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 6
);
  logic                 fetch_valid;
  logic [31:0]          fetch_instr;
  logic                 fetch_ready;
  logic                 issue_valid;
  logic [2:0]           issue_unit;
  logic [REG_SIZE-1:0]  issue_reg1;
  logic [REG_SIZE-1:0]  issue_reg2;
  logic [REG_SIZE-1:0]  issue_reg3;
  logic                 issue_hasimm;
  logic [WORD_SIZE-1:0] issue_imm;
  logic                 rs_ready;

  modport master (
    input  fetch_valid, fetch_instr, rs_ready,
    output fetch_ready, issue_valid, issue_unit, issue_reg1, issue_reg2,
           issue_reg3, issue_hasimm, issue_imm
  );

  modport slave (
    output fetch_valid, fetch_instr, rs_ready,
    input  fetch_ready, issue_valid, issue_unit, issue_reg1, issue_reg2,
           issue_reg3, issue_hasimm, issue_imm
  );
endinterface

// File: rtl/issue_fifo.sv
// Parameterised synchronous FIFO with occupancy count; head word read from
// the registered storage array, so a pushed word is visible one edge later.
module issue_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is not reset: an empty queue never exposes its contents.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == AW'(gi)))
          mem[gi] <= wdata;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/issue_queue.sv
// In-order issue buffer between fetch and the reservation stations: FIFO,
// head decode, illegal-opcode drop and halt sequencing. ISSUE_QUEUE_STATS_EN adds stall/issue counters.
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 6,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  issue_queue_if.master  bus,
  output logic [CW-1:0]  count,
  output logic           halted,
  output logic           illegal
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    issued_total
`endif
);

  logic [31:0]   head_word;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  iq_state_t     state_reg;
  logic          halted_reg;
  logic          illegal_reg;
  logic          fetch_ready_c;
  logic          take;
  logic          fetch_bad;
  logic          push;
  logic          pop;
  issue_fields_t head_fields;

  assign fetch_ready_c = !fifo_full && (state_reg == RUN);
  assign take          = bus.fetch_valid && fetch_ready_c;
  assign fetch_bad     = unit_is_illegal(bus.fetch_instr[UNIT_HI:UNIT_LO]);
  assign push          = take && !fetch_bad;
  assign pop           = !fifo_empty && bus.rs_ready;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.fetch_instr),
    .pop   (pop),
    .rdata (head_word),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fields read as zero while empty so the RS never sees stale storage.
  assign head_fields = fifo_empty ? '0 : decode_word(head_word);

  assign bus.fetch_ready  = fetch_ready_c;
  assign bus.issue_valid  = !fifo_empty;
  assign bus.issue_unit   = head_fields.unit;
  assign bus.issue_reg1   = REG_SIZE'(head_fields.reg1);
  assign bus.issue_reg2   = REG_SIZE'(head_fields.reg2);
  assign bus.issue_reg3   = REG_SIZE'(head_fields.reg3);
  assign bus.issue_hasimm = head_fields.hasimm;
  assign bus.issue_imm    = WORD_SIZE'(head_fields.imm);
  assign count            = fifo_count;
  assign halted           = halted_reg;
  assign illegal          = illegal_reg;

  // Intake closes once a halt is queued, so the halt is always the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= take && fetch_bad;
      case (state_reg)
        RUN: begin
          if (push && (bus.fetch_instr[UNIT_HI:UNIT_LO] == UNIT_HALT))
            state_reg <= HALT_PEND;
        end
        HALT_PEND: begin
          if (pop && (head_fields.unit == UNIT_HALT)) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= HALTED;
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] stall_reg;
  logic [31:0] issued_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg  <= '0;
      issued_reg <= '0;
    end else begin
      if (!fifo_empty && !bus.rs_ready && (stall_reg != '1))
        stall_reg <= stall_reg + 32'd1;
      if (pop && (issued_reg != '1))
        issued_reg <= issued_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
  assign issued_total = issued_reg;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a queue-based reference model checked on every
// falling edge, plus literal expectations derived by hand from the encoding.
module tb_issue_queue;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count;
  logic       halted;
  logic       illegal;
`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] issued_total;
`endif

  always #5 clk = ~clk;

  issue_queue_if #(.WORD_SIZE(32), .REG_SIZE(6)) bus ();

  issue_queue #(.DEPTH(DEPTH), .WORD_SIZE(32), .REG_SIZE(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count   (count),
    .halted  (halted),
    .illegal (illegal)
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .issued_total (issued_total)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words and a 3-valued phase.
  logic [31:0] mq[$];
  int          m_phase = 0;   // 0 accepting, 1 halt queued, 2 halted
  bit          m_halted = 0;
  bit          m_illegal = 0;
  longint      m_stall = 0;
  longint      m_issued = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_halted = 0;
      m_illegal = 0;
      m_stall = 0;
      m_issued = 0;
    end else begin
      bit rdy;
      bit vld;
      bit tk;
      bit bad;
      logic [31:0] w;
      rdy = (mq.size() != DEPTH) && (m_phase == 0);
      vld = (mq.size() != 0);
      tk  = bus.fetch_valid && rdy;
      bad = tk && ((bus.fetch_instr >> 29) >= 6);
      if (vld && !bus.rs_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (vld && bus.rs_ready) begin
        w = mq.pop_front();
        if (m_issued < 64'hFFFF_FFFF) m_issued++;
        if ((w >> 29) == 5) begin
          m_phase = 2;
          m_halted = 1;
        end
      end
      if (tk && !bad) begin
        mq.push_back(bus.fetch_instr);
        if ((bus.fetch_instr >> 29) == 5) m_phase = 1;
      end
      m_illegal = bad;
    end
  end

  always @(negedge clk) begin
    logic [31:0] w;
    int v;
    int e_has;
    w = (mq.size() != 0) ? mq[0] : 32'h0;
    e_has = (w >> 28) & 1;
    v = w & 32'hFFFF;
    if (v >= 32768) v -= 65536;
    chk("m_fetch_ready", bus.fetch_ready, (mq.size() != DEPTH) && (m_phase == 0));
    chk("m_issue_valid", bus.issue_valid, mq.size() != 0);
    chk("m_count", count, mq.size());
    chk("m_halted", halted, m_halted);
    chk("m_illegal", illegal, m_illegal);
    chk("m_unit", bus.issue_unit, w >> 29);
    chk("m_hasimm", bus.issue_hasimm, e_has);
    chk("m_reg1", bus.issue_reg1, (w >> 22) & 63);
    chk("m_reg2", bus.issue_reg2, (w >> 16) & 63);
    chk("m_reg3", bus.issue_reg3, e_has ? 0 : (w >> 10) & 63);
    chk("m_imm", bus.issue_imm, e_has ? v : 0);
`ifdef ISSUE_QUEUE_STATS_EN
    chk("m_stall_cycles", stall_cycles, m_stall[31:0]);
    chk("m_issued_total", issued_total, m_issued[31:0]);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill [8] = '{32'h40C40800, 32'h3142FFFC, 32'h00821000, 32'h7FFF8000,
                            32'h80400000, 32'h2A5A1234, 32'h5FC00001, 32'h13F07FFF};

  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = 32'h0;
    bus.rs_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_fetch_ready", bus.fetch_ready, 1);
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_imm", bus.issue_imm, 0);

    // add word 0x40C40800: unit 010, reg1 3, reg2 4 (bits 21:16 = 000100), reg3 2
    bus.fetch_valid = 1'b1; bus.fetch_instr = 32'h40C40800; bus.rs_ready = 1'b1;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("add_valid", bus.issue_valid, 1);
    chk("add_unit", bus.issue_unit, 3'b010);
    chk("add_reg1", bus.issue_reg1, 3);
    chk("add_reg2", bus.issue_reg2, 4);
    chk("add_reg3", bus.issue_reg3, 2);
    chk("add_hasimm", bus.issue_hasimm, 0);
    cyc();
    chk("add_popped_count", count, 0);
    bus.rs_ready = 1'b0;

    // 0x3142FFFC: unit 001, hasimm, reg1 5, reg2 2, imm -4
    bus.fetch_valid = 1'b1; bus.fetch_instr = 32'h3142FFFC;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("imm_unit", bus.issue_unit, 3'b001);
    chk("imm_hasimm", bus.issue_hasimm, 1);
    chk("imm_reg1", bus.issue_reg1, 5);
    chk("imm_reg2", bus.issue_reg2, 2);
    chk("imm_reg3", bus.issue_reg3, 0);
    chk("imm_value", bus.issue_imm, 32'hFFFFFFFC);
    cyc();
    chk("imm_hold", bus.issue_imm, 32'hFFFFFFFC);
    bus.rs_ready = 1'b1;
    cyc();
    bus.rs_ready = 1'b0;
    chk("imm_popped_count", count, 0);

    // fill to DEPTH with RS stalled, then offer one extra word
    for (int i = 0; i < 8; i++) begin
      bus.fetch_valid = 1'b1; bus.fetch_instr = fill[i];
      cyc();
    end
    bus.fetch_instr = 32'h80400000;
    cyc();
    cyc();
    chk("full_count", count, 8);
    chk("full_ready", bus.fetch_ready, 0);
    chk("full_head_unit", bus.issue_unit, 3'b010);
    chk("full_head_reg2", bus.issue_reg2, 4);
    bus.fetch_valid = 1'b0; bus.rs_ready = 1'b1;
    repeat (8) cyc();
    chk("drain_count", count, 0);
    chk("drain_valid", bus.issue_valid, 0);

    // simultaneous push and pop across pointer wrap
    bus.fetch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.fetch_instr = fill[i % 8];
      cyc();
    end
    chk("stream_count", count, 1);
    bus.fetch_valid = 1'b0;
    cyc();
    bus.rs_ready = 1'b0;
    chk("stream_drained", count, 0);

    // illegal opcode into empty queue
    bus.fetch_valid = 1'b1; bus.fetch_instr = 32'hE0001234;
    cyc();
    bus.fetch_valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_count", count, 0);
    chk("ill_valid", bus.issue_valid, 0);
    cyc();
    chk("ill_clear", illegal, 0);

    // illegal word in the same cycle as a pop
    bus.fetch_valid = 1'b1; bus.fetch_instr = 32'h80400000;
    cyc();
    bus.fetch_instr = 32'hC0000000; bus.rs_ready = 1'b1;
    cyc();
    bus.fetch_valid = 1'b0; bus.rs_ready = 1'b0;
    chk("illpop_count", count, 0);
    chk("illpop_pulse", illegal, 1);

    // halt sequencing: add, halt, then mv offered while intake closed
    bus.fetch_valid = 1'b1; bus.fetch_instr = 32'h40C40800;
    cyc();
    bus.fetch_instr = 32'hA0000000;
    cyc();
    chk("halt_intake_closed", bus.fetch_ready, 0);
    bus.fetch_instr = 32'h80400000;
    cyc();
    cyc();
    chk("halt_mv_rejected", count, 2);
    bus.rs_ready = 1'b1;
    cyc();
    chk("halt_add_issued", count, 1);
    chk("halt_not_yet", halted, 0);
    chk("halt_head_unit", bus.issue_unit, 3'b101);
    cyc();
    chk("halt_flag", halted, 1);
    chk("halt_count", count, 0);
    chk("halt_ready", bus.fetch_ready, 0);
    cyc();
    cyc();
    chk("halt_sticky", halted, 1);
    chk("halt_ready_sticky", bus.fetch_ready, 0);
    bus.fetch_valid = 1'b0; bus.rs_ready = 1'b0;

    // reset out of HALTED, fill 5, then asynchronous reset mid-cycle
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rerun_ready", bus.fetch_ready, 1);
    chk("rerun_halted", halted, 0);
    for (int i = 0; i < 5; i++) begin
      bus.fetch_valid = 1'b1; bus.fetch_instr = fill[i];
      cyc();
    end
    bus.fetch_valid = 1'b0;
    chk("fill5_count", count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", bus.issue_valid, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk("release_ready", bus.fetch_ready, 1);
    chk("release_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
